// File: rtl/arb_req_pkg.sv
// arb_requester shared types and default sizing.
// Optional feature macro: ARB_REQ_TIMEOUT_EN (grant wait timeout).
package arb_req_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    RELEASE
  } state_t;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_MAX_BURST = 4;
  localparam int DEF_TIMEOUT   = 16;

endpackage

// File: rtl/arb_req_if.sv
// arb_requester port bundle: producer side plus arbiter/bus side.
// slave = requester agent, master = environment driving it.
interface arb_req_if #(
  parameter int DATA_W = 8,
  parameter int LVL_W  = 3
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              req;
  logic              grant;
  logic              bus_valid;
  logic [DATA_W-1:0] bus_data;
  logic [LVL_W-1:0]  level;
  logic              timeout_err;

  modport slave (
    input  in_valid, in_data, grant,
    output in_ready, req, bus_valid,
    output bus_data, level, timeout_err
  );

  modport master (
    output in_valid, in_data, grant,
    input  in_ready, req, bus_valid,
    input  bus_data, level, timeout_err
  );

endinterface

// File: rtl/arb_req_fifo.sv
// Small synchronous FIFO buffering words for the requester.
// No bypass: a full FIFO refuses pushes even while popping.
module arb_req_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic              full,
  output logic              empty,
  output logic [LVL_W-1:0]  level,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d;
  logic [PTR_W-1:0]  rd_q, rd_d;
  logic [LVL_W-1:0]  cnt_q, cnt_d;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (cnt_q == LVL_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign level   = cnt_q;
  assign head    = mem_q[rd_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // next storage, pointers and occupancy
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) begin
      mem_d[wr_q] = wdata;
      wr_d        = wr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_d = rd_q + PTR_W'(1);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + LVL_W'(1);
      2'b01:   cnt_d = cnt_q - LVL_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // storage and pointer registers, flushed on reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/arb_requester.sv
// Requester agent for one arbiter port: buffers words, requests, bursts.
// Optional: `define ARB_REQ_TIMEOUT_EN adds grant-wait timeout retry.
module arb_requester
  import arb_req_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic     clk,
  input  logic     rst,
  arb_req_if.slave bus
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  if (MAX_BURST < 1 || MAX_BURST > 15 ||
      DEPTH < 2 || TIMEOUT < 2) begin : g_bad_cfg
    $error("arb_requester: illegal parameters");
  end

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic [3:0]        beat_q, beat_d;
  logic              full, empty;
  logic [LVL_W-1:0]  level;
  logic [DATA_W-1:0] head;
  logic              push;
  logic              bus_valid;
  logic              last_beat;
  logic              last_word;
  logic              timeout_hit;

  assign push      = bus.in_valid && !full;
  assign bus_valid = (state_q == XFER) && bus.grant && !empty;
  assign last_beat = (beat_q == 4'(MAX_BURST - 1));
  assign last_word = (level == LVL_W'(1));

  arb_req_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (bus_valid),
    .wdata (bus.in_data),
    .full  (full),
    .empty (empty),
    .level (level),
    .head  (head)
  );

`ifdef ARB_REQ_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT) + 1;

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              tmo_q, tmo_d;

  assign timeout_hit = (state_q == REQ) && !bus.grant &&
                       (wait_q == WAIT_W'(TIMEOUT - 1));

  // wait counter runs only while requesting without grant
  always_comb begin
    wait_d = '0;
    tmo_d  = timeout_hit;
    if (state_q == REQ && !bus.grant && !timeout_hit) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  // wait counter and error pulse registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      tmo_q  <= tmo_d;
    end
  end

  assign bus.timeout_err = tmo_q;
`else
  assign timeout_hit     = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  // state, req and beat count registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      beat_q  <= beat_d;
    end
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!empty) state_d = REQ;
      end
      REQ: begin
        if (bus.grant)        state_d = XFER;
        else if (timeout_hit) state_d = RELEASE;
      end
      XFER: begin
        if (!bus_valid)     state_d = RELEASE;
        else if (last_beat) state_d = RELEASE;
        else if (last_word) state_d = RELEASE;
      end
      RELEASE: begin
        state_d = empty ? IDLE : REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  // req follows the next state; beats counted per burst
  always_comb begin
    req_d  = (state_d == REQ) || (state_d == XFER);
    beat_d = beat_q;
    if (state_q == RELEASE) begin
      beat_d = '0;
    end else if (bus_valid) begin
      beat_d = beat_q + 4'd1;
    end
  end

  assign bus.in_ready  = !full;
  assign bus.req       = req_q;
  assign bus.bus_valid = bus_valid;
  assign bus.bus_data  = head;
  assign bus.level     = level;

endmodule

// File: tb/tb_arb_requester.sv
// Directed table-driven bench for arb_requester.
// Builds with or without ARB_REQ_TIMEOUT_EN.
module tb_arb_requester;

  typedef struct {
    logic       rst;
    logic       iv;
    logic [7:0] d;
    logic       g;
    logic       e_req;
    logic       e_bv;
    logic [7:0] e_d;
    logic [2:0] e_lvl;
    logic       e_rdy;
    logic       e_to;
  } vec_t;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  arb_req_if #(.DATA_W(8), .LVL_W(3)) bus_if ();

  arb_requester #(
    .DATA_W    (8),
    .DEPTH     (4),
    .MAX_BURST (4),
    .TIMEOUT   (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t v(
    input logic iv, input logic [7:0] d, input logic g,
    input logic req, input logic bv, input logic [7:0] ed,
    input logic [2:0] lvl, input logic rdy);
    vec_t t;
    t.rst = 1'b1; t.iv = iv; t.d = d; t.g = g;
    t.e_req = req; t.e_bv = bv; t.e_d = ed;
    t.e_lvl = lvl; t.e_rdy = rdy; t.e_to = 1'b0;
    return t;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input string nm);
    rst             = t.rst;
    bus_if.in_valid = t.iv;
    bus_if.in_data  = t.d;
    bus_if.grant    = t.g;
    @(negedge clk);
    chk({nm, ".req"}, int'(bus_if.req), int'(t.e_req));
    chk({nm, ".bus_valid"}, int'(bus_if.bus_valid), int'(t.e_bv));
    chk({nm, ".level"}, int'(bus_if.level), int'(t.e_lvl));
    chk({nm, ".in_ready"}, int'(bus_if.in_ready), int'(t.e_rdy));
    chk({nm, ".timeout"}, int'(bus_if.timeout_err), int'(t.e_to));
    if (t.e_bv || !t.rst)
      chk({nm, ".bus_data"}, int'(bus_if.bus_data), int'(t.e_d));
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];
  vec_t t;

  initial begin
    rst             = 1'b0;
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = '0;
    bus_if.grant    = 1'b0;

    // reset held with in_valid=1
    t = v(1, 8'hFF, 0, 0, 0, 8'h00, 0, 1); t.rst = 1'b0;
    tbl.push_back(t);
    tbl.push_back(t);
    // basic burst of three
    tbl.push_back(v(1, 8'hA1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(1, 8'hA2, 0, 0, 0, 0, 1, 1));
    tbl.push_back(v(1, 8'hA3, 1, 1, 0, 0, 2, 1));
    tbl.push_back(v(0, 0, 1, 1, 1, 8'hA1, 3, 1));
    tbl.push_back(v(0, 0, 1, 1, 1, 8'hA2, 2, 1));
    tbl.push_back(v(0, 0, 1, 1, 1, 8'hA3, 1, 1));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1));
    // burst cap: six words, grant held
    tbl.push_back(v(1, 8'hB1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(v(1, 8'hB2, 1, 0, 0, 0, 1, 1));
    tbl.push_back(v(1, 8'hB3, 1, 1, 0, 0, 2, 1));
    tbl.push_back(v(1, 8'hB4, 1, 1, 1, 8'hB1, 3, 1));
    tbl.push_back(v(1, 8'hB5, 1, 1, 1, 8'hB2, 3, 1));
    tbl.push_back(v(1, 8'hB6, 1, 1, 1, 8'hB3, 3, 1));
    tbl.push_back(v(0, 0, 1, 1, 1, 8'hB4, 3, 1));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 2, 1));
    tbl.push_back(v(0, 0, 1, 1, 0, 0, 2, 1));
    tbl.push_back(v(0, 0, 1, 1, 1, 8'hB5, 2, 1));
    tbl.push_back(v(0, 0, 1, 1, 1, 8'hB6, 1, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1));
    // grant lost after first beat
    tbl.push_back(v(1, 8'hC1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(1, 8'hC2, 0, 0, 0, 0, 1, 1));
    tbl.push_back(v(1, 8'hC3, 1, 1, 0, 0, 2, 1));
    tbl.push_back(v(0, 0, 1, 1, 1, 8'hC1, 3, 1));
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 2, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 2, 1));
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 2, 1));
    tbl.push_back(v(0, 0, 1, 1, 0, 0, 2, 1));
    tbl.push_back(v(0, 0, 1, 1, 1, 8'hC2, 2, 1));
    tbl.push_back(v(0, 0, 1, 1, 1, 8'hC3, 1, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1));
    // fill, refuse at full, push+pop
    tbl.push_back(v(1, 8'hD1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(1, 8'hD2, 0, 0, 0, 0, 1, 1));
    tbl.push_back(v(1, 8'hD3, 0, 1, 0, 0, 2, 1));
    tbl.push_back(v(1, 8'hD4, 0, 1, 0, 0, 3, 1));
    tbl.push_back(v(1, 8'hD5, 0, 1, 0, 0, 4, 0));
    tbl.push_back(v(1, 8'hD5, 1, 1, 0, 0, 4, 0));
    tbl.push_back(v(1, 8'hD5, 1, 1, 1, 8'hD1, 4, 0));
    tbl.push_back(v(1, 8'hD5, 1, 1, 1, 8'hD2, 3, 1));
    tbl.push_back(v(1, 8'hD6, 1, 1, 1, 8'hD3, 3, 1));
    tbl.push_back(v(0, 0, 1, 1, 1, 8'hD4, 3, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 2, 1));
    tbl.push_back(v(0, 0, 1, 1, 0, 0, 2, 1));
    tbl.push_back(v(1, 8'hD7, 1, 1, 1, 8'hD5, 2, 1));
    tbl.push_back(v(0, 0, 1, 1, 1, 8'hD6, 2, 1));
    // push on final beat does not extend the burst
    tbl.push_back(v(1, 8'hD8, 1, 1, 1, 8'hD7, 1, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(v(0, 0, 1, 1, 0, 0, 1, 1));
    tbl.push_back(v(0, 0, 1, 1, 1, 8'hD8, 1, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1));

    @(posedge clk);
    @(posedge clk);
    #1;
    foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

    // reset in the middle of a burst drops data
    apply(v(1, 8'hF1, 1, 0, 0, 0, 0, 1), "rst_a");
    apply(v(1, 8'hF2, 1, 0, 0, 0, 1, 1), "rst_b");
    apply(v(0, 0, 1, 1, 0, 0, 2, 1), "rst_c");
    t = v(0, 0, 1, 1, 1, 8'hF1, 2, 1); t.rst = 1'b0;
    apply(t, "rst_d");
    apply(v(0, 0, 1, 0, 0, 0, 0, 1), "rst_e");
    apply(v(0, 0, 0, 0, 0, 0, 0, 1), "rst_f");

    // grant wait: timeout retry or indefinite wait
    apply(v(1, 8'hE1, 0, 0, 0, 0, 0, 1), "to_push");
    apply(v(0, 0, 0, 0, 0, 0, 1, 1), "to_idle");
`ifdef ARB_REQ_TIMEOUT_EN
    for (int i = 0; i < 16; i++)
      apply(v(0, 0, 0, 1, 0, 0, 1, 1), $sformatf("to_wait%0d", i));
    t = v(0, 0, 0, 0, 0, 0, 1, 1); t.e_to = 1'b1;
    apply(t, "to_pulse");
`else
    for (int i = 0; i < 20; i++)
      apply(v(0, 0, 0, 1, 0, 0, 1, 1), $sformatf("to_wait%0d", i));
`endif
    apply(v(0, 0, 1, 1, 0, 0, 1, 1), "to_grant");
    apply(v(0, 0, 1, 1, 1, 8'hE1, 1, 1), "to_beat");
    apply(v(0, 0, 0, 0, 0, 0, 0, 1), "to_done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arb_requester.md
Name: arb_requester

Overview:
- Requester-side agent for the 2-way bus arbiter; it is the client that drives one `req` bit and consumes one `grant` bit.
- Buffers local write data in a small sync FIFO and raises `req` while data is pending.
- On grant, drains at most MAX_BURST words onto the shared bus, then drops `req` for one cycle so the arbiter can rotate.
- One instance is placed per arbiter port.

Parameters:
- DATA_W, 8, width of buffered/bus data word
- DEPTH, 4, FIFO entries (power of 2, >=2)
- MAX_BURST, 4, max words transferred per grant (1..15)
- TIMEOUT, 16, cycles in REQ without grant before timeout_err (needs ARB_REQ_TIMEOUT_EN)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-low reset (rst==0 resets on next rising clk)
- in_valid  in  1  local producer has a word
- in_ready  out  1  FIFO can accept; equals !full
- in_data  in  DATA_W  word to buffer; written when in_valid && in_ready
- req  out  1  request to arbiter (this port's bit)
- grant  in  1  this port's grant bit from arbiter
- bus_valid  out  1  word on bus_data is a transfer beat this cycle
- bus_data  out  DATA_W  FIFO head word
- level  out  $clog2(DEPTH)+1  current FIFO occupancy
- timeout_err  out  1  one-cycle pulse on grant timeout

Behaviour:
- Reset (rst==0 at edge):
  - FIFO flushed; state IDLE; beat/wait counters cleared.
  - Outputs: req=0, bus_valid=0, level=0, in_ready=1, timeout_err=0, bus_data=0.
  - Reset mid-burst drops everything; buffered data is lost.
- FIFO:
  - Push when in_valid && in_ready.
  - Pop only on a transfer beat.
  - Push and pop in the same cycle: both occur, level unchanged.
  - When full, in_ready=0 even if a pop occurs that cycle (no bypass).
  - Pointers wrap modulo DEPTH.
- `req` is a registered decode of state: 1 in REQ and XFER, 0 otherwise.
- bus_valid = (state==XFER) && grant && !empty (combinational on grant). bus_data = FIFO head.
- State IDLE:
  - If !empty, go to REQ.
  - Latency: a word pushed into an empty FIFO at edge t gives req=1 after edge t+1.
- State REQ:
  - grant==1 -> XFER; wait counter cleared.
  - Otherwise the wait counter increments.
- State XFER: each cycle with bus_valid, pop and increment beat_cnt. Go to RELEASE when any of:
  - beat_cnt reaches MAX_BURST on this beat;
  - this beat empties the FIFO;
  - grant==0 in XFER: no beat that cycle, remaining words are retried later.
- State RELEASE:
  - req=0 for exactly one cycle; beat_cnt cleared.
  - Next state REQ if !empty, else IDLE.
- Simultaneous events:
  - A push during the final XFER beat does not extend the burst past its exit condition.
  - grant==1 while in IDLE or RELEASE is ignored (bus_valid=0).
- A beat is never issued without grant==1 in the same cycle.

Optional Feature:
- Macro: ARB_REQ_TIMEOUT_EN
- Defined:
  - In REQ, when the wait counter reaches TIMEOUT-1 with grant==0, pulse timeout_err for one cycle and go to RELEASE (retry).
  - A grant in that same cycle takes priority: go to XFER, no error.
- Undefined:
  - REQ waits indefinitely.
  - timeout_err tied to 0; no wait counter is instantiated.

Decomposition:
- Package arb_req_pkg:
  - state typedef enum logic [1:0] {IDLE, REQ, XFER, RELEASE};
  - constants for default DATA_W, DEPTH, MAX_BURST, TIMEOUT.
- Sub-module arb_req_fifo:
  - parameterised sync FIFO (DATA_W, DEPTH);
  - outputs full, empty, level, head;
  - same clk/rst convention.
- The top module holds the FSM, beat counter and wait counter.

Test Plan:
- Reset: hold rst=0 for 2 cycles with in_valid=1 -> req=0, bus_valid=0, level=0, in_ready=1 throughout.
- Basic burst:
  - Push A1,A2,A3; grant=1 from the cycle req rises.
  - Expect bus_valid 3 consecutive cycles with A1,A2,A3.
  - Then req=0 for 1 cycle, then IDLE with level=0.
- Burst cap (MAX_BURST=4):
  - Push 6 words; grant held 1.
  - Expect 4 beats, 1 cycle req=0, req=1 again, 2 more beats.
- Grant loss:
  - Push 3 words; drop grant after the first beat.
  - Expect no beat that cycle, RELEASE, re-request.
  - Words 2,3 delivered in order on the next grant.
- Full/concurrent:
  - Fill 4 words: in_ready=0, level=4.
  - Push+pop in one cycle at level=2 -> level stays 2.
  - Push at full during a pop is refused.
- Timeout (ARB_REQ_TIMEOUT_EN, TIMEOUT=16):
  - Push 1 word, grant=0 -> timeout_err pulses after the 16th REQ cycle.
  - req drops 1 cycle, then reasserts.
  - Word is still delivered when grant later arrives.
